// File: rtl/tower_pkg.sv
// Shared types for the tower slot controller: command/status encodings, slot record, FSM states.
// Types only; no latency and no flow control.
package tower_pkg;

    localparam int TOWER_WIDTH_DFLT  = 32;
    localparam int TOWER_HEIGHT_DFLT = 32;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_PLACE  = 2'd1,
        OP_REMOVE = 2'd2,
        OP_CLEAR  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_FULL      = 2'd1,
        ST_DUPLICATE = 2'd2,
        ST_NOT_FOUND = 2'd3
    } status_t;

    typedef struct packed {
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
    } tower_slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tower_hit_detect.sv
// Rectangle comparator for one tower slot against the current pixel.
// Purely combinational; no flow control.
module tower_hit_detect
    import tower_pkg::*;
#(
    parameter int TOWER_WIDTH  = TOWER_WIDTH_DFLT,
    parameter int TOWER_HEIGHT = TOWER_HEIGHT_DFLT
) (
    input  tower_slot_t slot,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic        hit,
    output logic [10:0] off_x,
    output logic [10:0] off_y
);
    logic [11:0] px, py, x0, y0, x1, y1;

    // One extra bit keeps the right/bottom bound from wrapping for towers at the screen edge.
    assign px = {1'b0, pixel_x};
    assign py = {1'b0, pixel_y};
    assign x0 = {1'b0, slot.x};
    assign y0 = {1'b0, slot.y};
    assign x1 = x0 + 12'(TOWER_WIDTH);
    assign y1 = y0 + 12'(TOWER_HEIGHT);

    assign hit   = slot.valid && (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    assign off_x = pixel_x - slot.x;
    assign off_y = pixel_y - slot.y;

endmodule

// File: rtl/tower_slot_controller.sv
// Tower table owner: serialised place/remove/clear on a shadow table, per-pixel tower select from the active table.
// Pixel path 1 cycle; commands 1..NUM_SLOTS+2 cycles, cmdReady held low until the command completes.
module tower_slot_controller
    import tower_pkg::*;
#(
    parameter int NUM_SLOTS    = 8,
    parameter int TOWER_WIDTH  = TOWER_WIDTH_DFLT,
    parameter int TOWER_HEIGHT = TOWER_HEIGHT_DFLT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        cmdValid,
    input  logic [1:0]  cmdOp,
    input  logic [10:0] cmdX,
    input  logic [10:0] cmdY,
    output logic        cmdReady,
    output logic        cmdDone,
    output logic [1:0]  cmdStatus,
    output logic [4:0]  towerCount,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [3:0]  towerIndex
);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

    state_t      state, state_nxt;
    tower_slot_t shadow [NUM_SLOTS];
    tower_slot_t active [NUM_SLOTS];

    cmd_op_t       op_q;
    logic [10:0]   x_q, y_q;
    logic [IW-1:0] scan_idx, free_idx, match_idx;
    logic          free_found, match_found;
    logic          cur_free, cur_match, free_nxt, match_nxt, need_write;
    status_t       status_q, scan_status;
    logic [4:0]    count_q;
    logic          accept, scan_last;

    assign accept     = cmdValid && cmdReady;
    assign scan_last  = (scan_idx == LAST_IDX);
    assign cmdReady   = (state == IDLE);
    assign cmdDone    = (state == DONE);
    assign cmdStatus  = status_q;
    assign towerCount = count_q;

    // Fold the slot under inspection into the running results so the final scan cycle can decide.
    always_comb begin
        cur_free    = !shadow[scan_idx].valid;
        cur_match   = shadow[scan_idx].valid && (shadow[scan_idx].x == x_q) && (shadow[scan_idx].y == y_q);
        free_nxt    = free_found || cur_free;
        match_nxt   = match_found || cur_match;
        need_write  = 1'b0;
        scan_status = ST_OK;
        if (op_q == OP_PLACE) begin
            if (match_nxt)      scan_status = ST_DUPLICATE;
            else if (!free_nxt) scan_status = ST_FULL;
            else                need_write  = 1'b1;
        end else if (match_nxt) begin
            need_write = 1'b1;
        end else begin
            scan_status = ST_NOT_FOUND;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op_t'(cmdOp))
                        OP_NOP:   state_nxt = DONE;
                        OP_CLEAR: state_nxt = WRITE;
                        default:  state_nxt = SCAN;
                    endcase
                end
            end
            SCAN:    if (scan_last) state_nxt = need_write ? WRITE : DONE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            op_q        <= OP_NOP;
            x_q         <= '0;
            y_q         <= '0;
            scan_idx    <= '0;
            free_idx    <= '0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            match_found <= 1'b0;
            status_q    <= ST_OK;
            count_q     <= '0;
        end else begin
            if (accept) begin
                op_q        <= cmd_op_t'(cmdOp);
                x_q         <= cmdX;
                y_q         <= cmdY;
                scan_idx    <= '0;
                free_idx    <= '0;
                match_idx   <= '0;
                free_found  <= 1'b0;
                match_found <= 1'b0;
                status_q    <= ST_OK;
            end
            if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
                if (cur_free && !free_found) begin
                    free_found <= 1'b1;
                    free_idx   <= scan_idx;
                end
                if (cur_match && !match_found) begin
                    match_found <= 1'b1;
                    match_idx   <= scan_idx;
                end
                if (scan_last) status_q <= scan_status;
            end
            if (state == WRITE) begin
                case (op_q)
                    OP_CLEAR:  count_q <= '0;
                    OP_PLACE:  count_q <= count_q + 1'b1;
                    OP_REMOVE: count_q <= count_q - 1'b1;
                    default:   count_q <= count_q;
                endcase
            end
        end
    end

    // The active copy samples the shadow before any same-cycle write lands.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (startOfFrame) active <= shadow;
            if (state == WRITE) begin
                case (op_q)
                    OP_CLEAR:  for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
                    OP_PLACE:  shadow[free_idx] <= '{valid: 1'b1, x: x_q, y: y_q};
                    OP_REMOVE: shadow[match_idx] <= '0;
                    default:   ;
                endcase
            end
        end
    end

    logic        hit   [NUM_SLOTS];
    logic [10:0] off_x [NUM_SLOTS];
    logic [10:0] off_y [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        tower_hit_detect #(
            .TOWER_WIDTH  (TOWER_WIDTH),
            .TOWER_HEIGHT (TOWER_HEIGHT)
        ) u_hit (
            .slot    (active[g]),
            .pixel_x (pixelX),
            .pixel_y (pixelY),
            .hit     (hit[g]),
            .off_x   (off_x[g]),
            .off_y   (off_y[g])
        );
    end

    logic          sel_hit;
    logic [IW-1:0] sel_idx;
    logic [10:0]   sel_ox, sel_oy;

    // Walk high to low so the lowest hitting slot is the one left standing.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_ox  = '0;
        sel_oy  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_hit = 1'b1;
                sel_idx = IW'(i);
                sel_ox  = off_x[i];
                sel_oy  = off_y[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
            towerIndex      <= '0;
        end else begin
            InsideRectangle <= sel_hit;
            offsetX         <= sel_ox;
            offsetY         <= sel_oy;
            towerIndex      <= 4'(sel_idx);
        end
    end

endmodule

// File: tb/tb_tower_slot_controller.sv
// Directed bench for tower_slot_controller: command latency/status/count and registered pixel select.
module tb_tower_slot_controller;
    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX, pixelY;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic [10:0] cmdX, cmdY;
    logic        cmdReady, cmdDone;
    logic [1:0]  cmdStatus;
    logic [4:0]  towerCount;
    logic        InsideRectangle;
    logic [10:0] offsetX, offsetY;
    logic [3:0]  towerIndex;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [1:0] NOP = 2'd0, PLACE = 2'd1, REMOVE = 2'd2, CLEAR = 2'd3;
    localparam logic [1:0] S_OK = 2'd0, S_FULL = 2'd1, S_DUP = 2'd2, S_NF = 2'd3;

    tower_slot_controller #(.NUM_SLOTS(8), .TOWER_WIDTH(32), .TOWER_HEIGHT(32)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .cmdValid        (cmdValid),
        .cmdOp           (cmdOp),
        .cmdX            (cmdX),
        .cmdY            (cmdY),
        .cmdReady        (cmdReady),
        .cmdDone         (cmdDone),
        .cmdStatus       (cmdStatus),
        .towerCount      (towerCount),
        .InsideRectangle (InsideRectangle),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .towerIndex      (towerIndex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [10:0] x, input logic [10:0] y,
                       input logic exp_in, input logic [10:0] exp_ox, input logic [10:0] exp_oy,
                       input logic [3:0] exp_idx);
        pixelX = x;
        pixelY = y;
        tick();
        check({tag, ".inside"}, 32'(InsideRectangle), 32'(exp_in));
        check({tag, ".offx"}, 32'(offsetX), 32'(exp_ox));
        check({tag, ".offy"}, 32'(offsetY), 32'(exp_oy));
        check({tag, ".idx"}, 32'(towerIndex), 32'(exp_idx));
    endtask

    // exp_lat of 0 means latency is not checked for that command.
    task automatic cmd(input string tag, input logic [1:0] op, input logic [10:0] x, input logic [10:0] y,
                       input logic [1:0] exp_st, input int exp_lat, input logic [4:0] exp_cnt);
        int lat;
        check({tag, ".ready"}, 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdX     = x;
        cmdY     = y;
        tick();
        cmdValid = 1'b0;
        cmdOp    = NOP;
        lat      = 1;
        while (!cmdDone && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".done"}, 32'(cmdDone), 32'd1);
        check({tag, ".status"}, 32'(cmdStatus), 32'(exp_st));
        if (exp_lat != 0) check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".count"}, 32'(towerCount), 32'(exp_cnt));
        tick();
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        cmdValid     = 1'b0;
        cmdOp        = NOP;
        cmdX         = '0;
        cmdY         = '0;
        tick();
        tick();
        check("rst.ready", 32'(cmdReady), 32'd1);
        check("rst.done", 32'(cmdDone), 32'd0);
        check("rst.status", 32'(cmdStatus), 32'(S_OK));
        check("rst.count", 32'(towerCount), 32'd0);
        check("rst.inside", 32'(InsideRectangle), 32'd0);
        check("rst.offx", 32'(offsetX), 32'd0);
        check("rst.offy", 32'(offsetY), 32'd0);
        check("rst.idx", 32'(towerIndex), 32'd0);
        resetN = 1'b1;
        tick();

        // Place one tower; only visible after the frame boundary.
        cmd("place1", PLACE, 11'd100, 11'd200, S_OK, 10, 5'd1);
        pix("pre_sof", 11'd100, 11'd200, 1'b0, 11'd0, 11'd0, 4'd0);
        sof();
        pix("inside", 11'd110, 11'd205, 1'b1, 11'd10, 11'd5, 4'd0);
        pix("corner", 11'd131, 11'd231, 1'b1, 11'd31, 11'd31, 4'd0);
        pix("right_out", 11'd132, 11'd200, 1'b0, 11'd0, 11'd0, 4'd0);
        pix("left_out", 11'd99, 11'd200, 1'b0, 11'd0, 11'd0, 4'd0);
        pix("top_left", 11'd100, 11'd200, 1'b1, 11'd0, 11'd0, 4'd0);

        // Fill the table, overflow, then duplicate.
        for (int i = 1; i < 8; i++)
            cmd("fill", PLACE, 11'(300 + 40 * i), 11'd10, S_OK, 10, 5'(i + 1));
        cmd("full", PLACE, 11'd900, 11'd900, S_FULL, 0, 5'd8);
        cmd("dup", PLACE, 11'd100, 11'd200, S_DUP, 0, 5'd8);
        cmd("clear1", CLEAR, 11'd0, 11'd0, S_OK, 2, 5'd0);
        sof();
        pix("cleared", 11'd110, 11'd205, 1'b0, 11'd0, 11'd0, 4'd0);

        // Overlapping towers: lowest slot wins until it is removed.
        cmd("ov0", PLACE, 11'd50, 11'd50, S_OK, 10, 5'd1);
        cmd("ov1", PLACE, 11'd60, 11'd60, S_OK, 10, 5'd2);
        sof();
        pix("ov_both", 11'd70, 11'd70, 1'b1, 11'd20, 11'd20, 4'd0);
        cmd("rm50", REMOVE, 11'd50, 11'd50, S_OK, 10, 5'd1);
        pix("rm_pending", 11'd70, 11'd70, 1'b1, 11'd20, 11'd20, 4'd0);
        sof();
        pix("ov_slot1", 11'd70, 11'd70, 1'b1, 11'd10, 11'd10, 4'd1);
        cmd("rm_missing", REMOVE, 11'd5, 11'd5, S_NF, 0, 5'd1);
        sof();
        pix("after_nf", 11'd70, 11'd70, 1'b1, 11'd10, 11'd10, 4'd1);

        // Freed slot 0 is reused; tower near the right edge must not wrap.
        cmd("edge", PLACE, 11'd2040, 11'd100, S_OK, 10, 5'd2);
        sof();
        pix("edge_in", 11'd2045, 11'd110, 1'b1, 11'd5, 11'd10, 4'd0);
        pix("edge_lo", 11'd5, 11'd110, 1'b0, 11'd0, 11'd0, 4'd0);
        cmd("nop", NOP, 11'd0, 11'd0, S_OK, 1, 5'd2);

        // Reset in the middle of a scan aborts the command and empties both tables.
        check("mid.ready", 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdOp    = PLACE;
        cmdX     = 11'd400;
        cmdY     = 11'd400;
        tick();
        cmdValid = 1'b0;
        tick();
        tick();
        check("mid.busy", 32'(cmdReady), 32'd0);
        resetN = 1'b0;
        #1;
        check("mid.done", 32'(cmdDone), 32'd0);
        check("mid.ready_rst", 32'(cmdReady), 32'd1);
        check("mid.count", 32'(towerCount), 32'd0);
        check("mid.inside", 32'(InsideRectangle), 32'd0);
        tick();
        resetN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mid.no_done", 32'(cmdDone), 32'd0);
        end
        pix("mid.active_clr", 11'd2045, 11'd110, 1'b0, 11'd0, 11'd0, 4'd0);
        sof();
        pix("mid.shadow_clr", 11'd2045, 11'd110, 1'b0, 11'd0, 11'd0, 4'd0);

        // Shadow write in the same cycle as startOfFrame lands one frame later.
        check("co.ready", 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdOp    = PLACE;
        cmdX     = 11'd200;
        cmdY     = 11'd200;
        tick();
        cmdValid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("co.done", 32'(cmdDone), 32'd1);
        check("co.status", 32'(cmdStatus), 32'(S_OK));
        check("co.count", 32'(towerCount), 32'd1);
        pix("co.same_frame", 11'd210, 11'd210, 1'b0, 11'd0, 11'd0, 4'd0);
        sof();
        pix("co.next_frame", 11'd210, 11'd210, 1'b1, 11'd10, 11'd10, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
